// File: rtl/data_mem_arbiter.sv
// Data memory port arbiter between the pipeline MEM stage and a DMA engine.
// Core has priority; a starvation counter guarantees the DMA a slot.
module data_mem_arbiter #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_read,
  input  logic                  core_write,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic [2:0]            core_funct3,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  input  logic [2:0]            dma_funct3,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_funct3,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  owner
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       core_active;
  logic       dma_read_gnt;

  assign core_active = core_read | core_write;

  // Owner is decided combinationally every cycle; reset forces the core side idle.
  assign owner        = rst & dma_req & (~core_active | (starve_cnt == LIMIT));
  assign dma_gnt      = dma_req & owner;
  assign core_stall   = owner & core_active;
  assign dma_read_gnt = dma_gnt & ~dma_we;

  assign mem_addr   = owner ? dma_addr   : core_addr;
  assign mem_wdata  = owner ? dma_wdata  : core_wdata;
  assign mem_funct3 = owner ? dma_funct3 : core_funct3;

  // Read and write together from the core is treated as a store.
  assign mem_write = rst & (owner ? dma_we  : core_write);
  assign mem_read  = rst & (owner ? ~dma_we : (core_read & ~core_write));

  assign core_rdata = (rst & ~owner) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!dma_req || dma_gnt) begin
      starve_cnt <= '0;
    end else if (core_active && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_read_gnt;
      if (dma_read_gnt) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: behavioural memory, DMA read-response
// scoreboard queue, immediate-assertion checks.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_read, core_write;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata;
  logic [2:0]  core_funct3;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        dma_req, dma_we;
  logic [8:0]  dma_addr;
  logic [31:0] dma_wdata;
  logic [2:0]  dma_funct3;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata;
  logic        owner;

  logic        bd_we;
  logic [8:0]  bd_addr;
  logic [31:0] bd_data;
  logic [31:0] mem_model [0:127];

  int passed = 0;
  int total  = 0;
  logic [31:0] rsp_q [$];

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .core_read(core_read), .core_write(core_write), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_funct3(dma_funct3),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  // Word-granular memory with combinational read and a backdoor load port.
  assign mem_rdata = mem_read ? mem_model[mem_addr[8:2]] : 32'h0;

  always @(posedge clk) begin
    if (bd_we) mem_model[bd_addr[8:2]] <= bd_data;
    else if (mem_write) mem_model[mem_addr[8:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-14s obs=%08h exp=%08h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  // Response side of the scoreboard: anything pushed last cycle is due now.
  task automatic check_rsp();
    logic [31:0] exp;
    check("rvalid", {31'b0, dma_rvalid}, {31'b0, rsp_q.size() != 0});
    if (rsp_q.size() != 0) begin
      exp = rsp_q.pop_front();
      check("rdata", dma_rdata, exp);
    end
  endtask

  task automatic mid();
    @(negedge clk);
    check_rsp();
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_read = 0; core_write = 0; dma_req = 0; dma_we = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    core_addr = '0; core_wdata = '0; core_funct3 = 3'b010;
    dma_addr = '0; dma_wdata = '0; dma_funct3 = 3'b010;
    bd_we = 0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < 128; i++) mem_model[i] = 32'h0;

    // Reset: outputs forced low even with both requesters active
    core_write = 1; dma_req = 1; dma_we = 1;
    #2;
    check("rst_owner", {31'b0, owner}, 32'h0);
    check("rst_gnt", {31'b0, dma_gnt}, 32'h0);
    check("rst_stall", {31'b0, core_stall}, 32'h0);
    check("rst_mem_en", {30'b0, mem_read, mem_write}, 32'h0);
    check("rst_core_rd", core_rdata, 32'h0);
    check("rst_rvalid", {31'b0, dma_rvalid}, 32'h0);
    check("rst_rdata", dma_rdata, 32'h0);
    idle();
    bd_we = 1;
    bd_addr = 9'h010; bd_data = 32'hDEADBEEF; edge_step();
    bd_addr = 9'h020; bd_data = 32'h12345678; edge_step();
    bd_addr = 9'h080; bd_data = 32'hCAFEF00D; edge_step();
    bd_addr = 9'h0C0; bd_data = 32'h0BADF00D; edge_step();
    bd_we = 0;
    rst = 1'b1;

    // Core load only
    core_read = 1; core_addr = 9'h010;
    mid();
    check("ld_rdata", core_rdata, 32'hDEADBEEF);
    check("ld_stall", {31'b0, core_stall}, 32'h0);
    check("ld_gnt", {31'b0, dma_gnt}, 32'h0);
    check("ld_mem_rd", {31'b0, mem_read}, 32'h1);
    edge_step();

    // DMA read with core idle, response next cycle
    idle(); dma_req = 1; dma_we = 0; dma_addr = 9'h020;
    mid();
    check("dr_gnt", {31'b0, dma_gnt}, 32'h1);
    check("dr_owner", {31'b0, owner}, 32'h1);
    check("dr_addr", {23'b0, mem_addr}, 32'h020);
    rsp_q.push_back(32'h12345678);
    edge_step();
    idle(); core_addr = 9'h0C0;
    mid();
    check("idle_addr", {23'b0, mem_addr}, 32'h0C0);
    check("idle_en", {30'b0, mem_read, mem_write}, 32'h0);
    edge_step();
    mid();
    edge_step();

    // Starvation: 4 core stores win, 5th cycle goes to the DMA read
    dma_req = 1; dma_we = 0; dma_addr = 9'h080;
    core_write = 1; core_addr = 9'h100;
    for (int i = 0; i < 4; i++) begin
      core_wdata = 32'h100 + i;
      mid();
      check($sformatf("sv_gnt%0d", i), {31'b0, dma_gnt}, 32'h0);
      check($sformatf("sv_stall%0d", i), {31'b0, core_stall}, 32'h0);
      check($sformatf("sv_wd%0d", i), mem_wdata, 32'h100 + i);
      edge_step();
    end
    mid();
    check("sv5_gnt", {31'b0, dma_gnt}, 32'h1);
    check("sv5_stall", {31'b0, core_stall}, 32'h1);
    check("sv5_core_rd", core_rdata, 32'h0);
    check("sv5_addr", {23'b0, mem_addr}, 32'h080);
    rsp_q.push_back(32'hCAFEF00D);
    edge_step();
    dma_req = 0;
    mid();
    check("sv6_stall", {31'b0, core_stall}, 32'h0);
    check("sv6_mem_wr", {31'b0, mem_write}, 32'h1);
    edge_step();

    // Same-address write collision: core first, DMA on the next idle cycle
    core_write = 1; core_addr = 9'h040; core_wdata = 32'hAAAA0000;
    dma_req = 1; dma_we = 1; dma_addr = 9'h040; dma_wdata = 32'h5555FFFF;
    mid();
    check("cw_gnt", {31'b0, dma_gnt}, 32'h0);
    check("cw_wdata", mem_wdata, 32'hAAAA0000);
    edge_step();
    check("cw_core_mem", mem_model[9'h040 >> 2], 32'hAAAA0000);
    core_write = 0;
    mid();
    check("cw_dma_gnt", {31'b0, dma_gnt}, 32'h1);
    check("cw_dma_wd", mem_wdata, 32'h5555FFFF);
    check("cw_dma_wr", {31'b0, mem_write}, 32'h1);
    edge_step();
    idle();
    check("cw_final", mem_model[9'h040 >> 2], 32'h5555FFFF);
    mid();
    edge_step();

    // dma_req dropped after 3 wins restarts the count
    core_write = 1; core_addr = 9'h104;
    dma_req = 1; dma_we = 1; dma_addr = 9'h108; dma_wdata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      mid();
      check($sformatf("dp_gnt%0d", i), {31'b0, dma_gnt}, 32'h0);
      edge_step();
    end
    dma_req = 0;
    mid();
    edge_step();
    dma_req = 1;
    for (int i = 0; i < 4; i++) begin
      mid();
      check($sformatf("dp_re_gnt%0d", i), {31'b0, dma_gnt}, 32'h0);
      edge_step();
    end
    mid();
    check("dp_re_gnt4", {31'b0, dma_gnt}, 32'h1);
    edge_step();
    idle();

    // Reset with a partially built starve count: count must restart at 0
    core_write = 1; dma_req = 1; dma_we = 1;
    mid(); edge_step();
    mid(); edge_step();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      check($sformatf("rc_gnt%0d", i), {31'b0, dma_gnt}, 32'h0);
      edge_step();
    end
    mid();
    check("rc_gnt4", {31'b0, dma_gnt}, 32'h1);
    edge_step();
    idle();

    // DMA read granted, reset pulsed before the response edge
    dma_req = 1; dma_we = 0; dma_addr = 9'h020;
    mid();
    check("rr_gnt", {31'b0, dma_gnt}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    check("rr_owner", {31'b0, owner}, 32'h0);
    check("rr_gnt_rst", {31'b0, dma_gnt}, 32'h0);
    check("rr_mem_en", {30'b0, mem_read, mem_write}, 32'h0);
    edge_step();
    idle();
    check("rr_rvalid", {31'b0, dma_rvalid}, 32'h0);
    check("rr_rdata", dma_rdata, 32'h0);
    rst = 1'b1;
    mid();
    edge_step();
    mid();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, data memory byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32, data word width.
REQ-003 Parameter STARVE_LIMIT, default 4, max consecutive core wins over a pending DMA request; legal range 1-15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 core_read  input  1  MEM-stage load enable.
REQ-007 core_write  input  1  MEM-stage store enable.
REQ-008 core_addr  input  ADDR_WIDTH  MEM-stage address.
REQ-009 core_wdata  input  DATA_WIDTH  MEM-stage store data.
REQ-010 core_funct3  input  3  MEM-stage access size/sign code.
REQ-011 core_rdata  output  DATA_WIDTH  load data to MEM/WB register.
REQ-012 core_stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM this cycle; inserts bubble into MEM/WB.
REQ-013 dma_req  input  1  DMA request valid.
REQ-014 dma_we  input  1  DMA direction; 1 = write, 0 = read.
REQ-015 dma_addr / dma_wdata / dma_funct3  input  ADDR_WIDTH / DATA_WIDTH / 3  DMA request fields.
REQ-016 dma_gnt  output  1  DMA request accepted this cycle.
REQ-017 dma_rvalid  output  1  DMA read data valid.
REQ-018 dma_rdata  output  DATA_WIDTH  registered DMA read data.
REQ-019 mem_addr / mem_wdata / mem_funct3  output  ADDR_WIDTH / DATA_WIDTH / 3  data memory request fields.
REQ-020 mem_read / mem_write  output  1 / 1  data memory enables.
REQ-021 mem_rdata  input  DATA_WIDTH  data memory read data, combinational from mem_addr/mem_read.
REQ-022 owner  output  1  debug; 1 = DMA drives memory this cycle.

Function
REQ-023 Core access active when core_read|core_write; both high is illegal and treated as write.
REQ-024 Owner decision combinational per cycle: DMA owns if dma_req and (no core access, or starve_cnt == STARVE_LIMIT); otherwise core owns.
REQ-025 starve_cnt: 4-bit register; +1 when core wins while dma_req high; cleared on any DMA grant or any cycle with dma_req low; saturates at STARVE_LIMIT.
REQ-026 dma_gnt = dma_req & owner; transfer occurs in that cycle only; DMA holds request fields stable until dma_gnt.
REQ-027 core_stall = owner & core access active; no stall when core idle.
REQ-028 Memory port muxes all request fields from the owner; mem_read/mem_write = 0 when owner has no access.
REQ-029 Idle cycles (no core access, no dma_req): mem_addr = core_addr, enables 0, owner = 0.
REQ-030 core_rdata = mem_rdata when core owns; 0 while core_stall.
REQ-031 DMA read: dma_rdata registers mem_rdata at the grant edge; dma_rvalid high exactly one cycle after grant, for one cycle.
REQ-032 DMA write: no response; dma_rvalid stays 0.
REQ-033 Back-to-back DMA grants permitted; dma_rvalid may stay high on consecutive cycles.
REQ-034 Simultaneous core and DMA writes to the same address: only owner's write reaches memory; loser retries next cycle (core via stall, DMA via held dma_req).
REQ-035 STARVE_LIMIT reached with core active: DMA wins exactly one cycle, counter cleared, core proceeds next cycle.

Reset
REQ-036 rst low asynchronously clears starve_cnt, dma_rvalid, dma_rdata to 0.
REQ-037 During reset, dma_gnt, core_stall, mem_read, mem_write, owner forced 0; core_rdata 0.
REQ-038 Reset asserted mid-transaction: pending dma_rvalid dropped; no retry, no partial write.

Verification
REQ-039 Core load addr 0x010 only, mem_rdata 0xDEADBEEF -> core_rdata 0xDEADBEEF same cycle, core_stall 0, dma_gnt 0.
REQ-040 Core idle, DMA read addr 0x020, mem_rdata 0x12345678 -> dma_gnt 1 cycle N, dma_rvalid 1 and dma_rdata 0x12345678 cycle N+1.
REQ-041 Core stores every cycle, dma_req held, STARVE_LIMIT 4 -> core wins 4 cycles, cycle 5 dma_gnt 1 and core_stall 1, cycle 6 core resumes.
REQ-042 Core and DMA both write 0x040 (0xAAAA0000 / 0x5555FFFF), counter 0 -> core write committed, DMA granted next idle or starvation cycle; final memory value is the later writer.
REQ-043 DMA read granted, rst pulsed low before next edge -> dma_rvalid 0, all outputs 0, starve_cnt 0 after release.
REQ-044 dma_req dropped after 3 core wins, reasserted -> counter restarts at 0, 4 further core wins before DMA grant.
